// File: rtl/cmd_arb_pkg.sv
// Shared types and constants for the cmd_proc port arbiter.
package cmd_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} arb_state_t;

    localparam logic [3:0]  OPC_Y = 4'h4;
    localparam logic [3:0]  OPC_X = 4'h5;
    localparam int unsigned CMD_W = 16;
    localparam int unsigned TMR_W = 24;

    // Opcode field of a command word.
    function automatic logic [3:0] cmd_opc(input logic [CMD_W-1:0] c);
        return c[15:12];
    endfunction

endpackage

// File: rtl/cmd_arbiter_if.sv
// Requester and cmd_proc handshake bundle for cmd_arbiter.
interface cmd_arbiter_if;
    import cmd_arb_pkg::*;

    logic [CMD_W-1:0] cmd_UART;
    logic             cmd_rdy_UART;
    logic             clr_UART;
    logic [CMD_W-1:0] cmd_tour;
    logic             cmd_rdy_tour;
    logic             clr_cmd_rdy_tour;
    logic             send_resp_tour;
    logic             resp_vld_UART;
    logic [CMD_W-1:0] cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic             owner_tour;
    logic             err_timeout;

    // Requesters and cmd_proc side
    modport master (
        output cmd_UART, cmd_rdy_UART, cmd_tour, cmd_rdy_tour, clr_cmd_rdy, send_resp,
        input  clr_UART, clr_cmd_rdy_tour, send_resp_tour, resp_vld_UART,
               cmd, cmd_rdy, owner_tour, err_timeout
    );

    // Arbiter side
    modport slave (
        input  cmd_UART, cmd_rdy_UART, cmd_tour, cmd_rdy_tour, clr_cmd_rdy, send_resp,
        output clr_UART, clr_cmd_rdy_tour, send_resp_tour, resp_vld_UART,
               cmd, cmd_rdy, owner_tour, err_timeout
    );

endinterface

// File: rtl/cmd_fifo.sv
// UART command buffer; extra pointer MSB separates full from empty.
module cmd_fifo
    import cmd_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] din,
    output logic [CMD_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; a pop frees the slot a simultaneous push reuses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cmd_arbiter.sv
// Grants the cmd_proc port to the UART FIFO or the tour sequencer, one command at a time.
module cmd_arbiter
    import cmd_arb_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [3:0]  PAIR_OPC = OPC_Y,
    parameter logic [23:0] TIMEOUT  = 24'd10_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    cmd_arbiter_if.slave bus
);

    arb_state_t       r_state;
    logic [CMD_W-1:0] r_cmd_q;
    logic             r_cmd_rdy;
    logic             r_owner_tour;
    logic             r_last_tour;
    logic             r_pair_lock;
    logic             r_err;
    logic             r_clr_uart_q;
    logic [TMR_W-1:0] r_timer;

    logic [CMD_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_accept;
    logic             w_resp;
    logic             w_ut;
    logic             w_tr;
    logic             w_grant;
    logic             w_grant_tour;

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.cmd_UART),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_accept = (r_state == ISSUE) && bus.clr_cmd_rdy;
    assign w_resp   = (r_state == BUSY) && bus.send_resp;
    assign w_pop    = w_accept && !r_owner_tour;
    // Skip the cycle after a push: the wrapper is still dropping its ready.
    assign w_push   = bus.cmd_rdy_UART && !r_clr_uart_q && (!w_full || w_pop);

    // A pending Y/X pair locks UART out until the tour side completes it.
    assign w_ut         = !w_empty && !r_pair_lock;
    assign w_tr         = bus.cmd_rdy_tour;
    assign w_grant      = (r_state == IDLE) && (w_ut || w_tr);
    assign w_grant_tour = w_tr && (!w_ut || !r_last_tour);

    assign bus.clr_UART         = w_push;
    assign bus.clr_cmd_rdy_tour = w_accept && r_owner_tour;
    assign bus.send_resp_tour   = w_resp && r_owner_tour;
    assign bus.resp_vld_UART    = w_resp && !r_owner_tour;
    assign bus.cmd              = r_cmd_q;
    assign bus.cmd_rdy          = r_cmd_rdy;
    assign bus.owner_tour       = r_owner_tour;
    assign bus.err_timeout      = r_err;

    // Grant / issue / wait-for-response sequencing with response timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cmd_q      <= '0;
            r_cmd_rdy    <= 1'b0;
            r_owner_tour <= 1'b0;
            r_last_tour  <= 1'b1;
            r_pair_lock  <= 1'b0;
            r_err        <= 1'b0;
            r_clr_uart_q <= 1'b0;
            r_timer      <= '0;
        end else begin
            r_clr_uart_q <= w_push;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_cmd_q      <= w_grant_tour ? bus.cmd_tour : w_head;
                        r_owner_tour <= w_grant_tour;
                        r_last_tour  <= w_grant_tour;
                        r_cmd_rdy    <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.clr_cmd_rdy) begin
                        r_cmd_rdy <= 1'b0;
                        r_timer   <= '0;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.send_resp) begin
                        if (r_owner_tour) r_pair_lock <= (cmd_opc(r_cmd_q) == PAIR_OPC);
                        r_state <= IDLE;
                    end else if (r_timer == TIMEOUT - 24'd1) begin
                        r_err       <= 1'b1;
                        r_pair_lock <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
Shares the single cmd_proc command port between two requesters: the UART host path and the tour command sequencer. UART commands go into a small FIFO so the UART wrapper is released at once. Tour commands are taken directly from the sequencer's ready/clear handshake. The block grants one command at a time, holds the grant until cmd_proc responds, routes the response back to the owner, keeps Y/X tour move pairs atomic, and flags a cmd_proc timeout.

Parameters:
DEPTH, 4, UART FIFO entries (power of 2, 2..16)
PAIR_OPC, 4'h4, cmd[15:12] opcode of the first half of a tour move pair (Y move)
TIMEOUT, 24'd10_000_000, cycles allowed from clr_cmd_rdy to send_resp

Ports:
clk  in  1  50MHz system clock
rst_n  in  1  asynchronous active-low reset
cmd_UART  in  16  command from UART_wrapper
cmd_rdy_UART  in  1  UART command valid, held until clr_UART
clr_UART  out  1  one-cycle pulse: UART command accepted into FIFO
cmd_tour  in  16  command from tour sequencer
cmd_rdy_tour  in  1  tour command valid, held until clr_cmd_rdy_tour
clr_cmd_rdy_tour  out  1  one-cycle pulse: tour command accepted by cmd_proc
send_resp_tour  out  1  one-cycle pulse: tour command completed
resp_vld_UART  out  1  one-cycle pulse: UART command completed
cmd  out  16  command to cmd_proc
cmd_rdy  out  1  command valid to cmd_proc
clr_cmd_rdy  in  1  cmd_proc accepted cmd
send_resp  in  1  cmd_proc finished cmd
owner_tour  out  1  1 = current/last grant is tour
err_timeout  out  1  sticky; cleared only by reset

Behaviour:
- Reset: FSM in IDLE; FIFO empty; cmd_q=0; cmd=0; cmd_rdy=0; all pulse outputs 0; owner_tour=0; pair_lock=0; last_owner=tour (UART wins the first tie); timer=0; err_timeout=0. Reset mid-operation abandons the in-flight command with no response pulse.
- FIFO push: if cmd_rdy_UART && !full && !clr_UART_q, push cmd_UART and pulse clr_UART in that cycle. The clr_UART_q guard blocks a double push while the wrapper drops its ready. If the FIFO is full, there is no pulse and the wrapper stays held. Push and pop in the same cycle are both allowed, including when full (pop frees the slot first), so count is unchanged.
- FSM states: IDLE, ISSUE, BUSY.
- IDLE, candidates are ut = !empty and tr = cmd_rdy_tour:
  - pair_lock=1: only tr may be granted.
  - Both ut and tr: grant the one that is not last_owner (round-robin).
  - Only one candidate: grant it.
  - On grant: latch cmd_q (FIFO head or cmd_tour), set owner_tour and last_owner, go to ISSUE.
  - Latency: cmd_rdy rises the cycle after the request is seen in IDLE.
- ISSUE: cmd=cmd_q, cmd_rdy=1. On clr_cmd_rdy:
  - Owner UART: pop the FIFO.
  - Owner tour: pulse clr_cmd_rdy_tour in the same cycle.
  - Drop cmd_rdy, clear timer, go to BUSY.
  - No timeout in ISSUE; cmd_proc may take as long as it needs to accept.
- BUSY: cmd holds cmd_q, cmd_rdy=0, timer increments.
  - On send_resp: pulse send_resp_tour or resp_vld_UART (combinational with send_resp) and go to IDLE.
  - Pair lock update, tour owner only: if cmd_q[15:12]==PAIR_OPC, set pair_lock. Otherwise, if pair_lock=1, clear it.
  - If timer==TIMEOUT-1 without send_resp: set err_timeout, clear pair_lock, go to IDLE, no response pulse.
  - send_resp in the terminal cycle wins over timeout.
- A clr_cmd_rdy or send_resp in the wrong state is ignored.
- cmd_rdy and cmd are registered outputs. clr_UART, clr_cmd_rdy_tour, send_resp_tour and resp_vld_UART are combinational pulses.
- FIFO pointers are log2(DEPTH)+1 bits, wrap naturally. full = MSBs differ and LSBs equal; empty = pointers equal.

Decomposition:
- Package cmd_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, BUSY} arb_state_t
  - localparam OPC_Y=4'h4, OPC_X=4'h5
- Sub-module cmd_fifo (parameter DEPTH, 16-bit wide; ports push, pop, din, dout, full, empty) holds the UART buffer.
- Arbitration and the FSM stay in cmd_arbiter.

Test Plan:
- UART alone: cmd_UART=16'h2000 for 1 cycle → clr_UART same cycle. cmd=2000 with cmd_rdy 2 cycles later. clr_cmd_rdy → BUSY. send_resp → resp_vld_UART=1, send_resp_tour=0.
- Pair atomicity: tour 16'h4002 completes while a UART 16'h3000 is queued, then tour 16'h5BF2 is presented → 5BF2 granted before 3000. After 5BF2's send_resp, 3000 is granted.
- Round-robin: UART 16'h1111 queued and cmd_tour=16'h5BF1 both present in IDLE after reset → 1111 first, 5BF1 next.
- FIFO full: 5 UART commands pushed with cmd_proc stalled in ISSUE → 4 clr_UART pulses, 5th held. First clr_cmd_rdy pops, 5th is accepted that cycle, and FIFO order is preserved.
- Timeout (TIMEOUT=16 in bench): no send_resp after clr_cmd_rdy → err_timeout=1 at cycle 16, FSM back in IDLE, pair_lock cleared, next request granted normally.
- Reset mid-BUSY: rst_n low → cmd_rdy=0, FIFO empty, no response pulses, err_timeout=0.
